// File: rtl/mdu_stall_ctrl.sv
// MULT/DIV latency sequencer and D-stage stall merge for the pipeline around the MDU.
// Optional stall statistics counters are enabled by defining MDU_STALL_STAT_EN.
module mdu_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_md_use,
  input  logic             D_stall_data,
  input  logic             E_mult_start,
  input  logic             E_div_start,
  output logic             mdu_busy,
  output logic             mdu_start,
  output logic             mdu_done,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             stall,
  output logic             pc_en,
  output logic             fd_wren,
`ifdef MDU_STALL_STAT_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      mdu_stall_cnt,
`endif
  output logic             de_flush
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;
  logic             mdu_term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy_cnt <= '0;
      mdu_done <= 1'b0;
    end else begin
      state    <= state_next;
      busy_cnt <= cnt_next;
      mdu_done <= done_next;
    end
  end

  // Div is checked first so it wins when both starts arrive together.
  always_comb begin
    state_next = state;
    cnt_next   = busy_cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (E_div_start) begin
          cnt_next   = CNT_W'(DIV_CYCLES);
          state_next = BUSY;
        end else if (E_mult_start) begin
          cnt_next   = CNT_W'(MULT_CYCLES);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (busy_cnt == CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = busy_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign mdu_busy  = (state == BUSY);
  assign mdu_start = (E_mult_start | E_div_start) & (state == IDLE);

  // The start cycle already counts as busy so a dependent mfhi/mflo stalls at once.
  assign mdu_term  = D_md_use & (mdu_busy | mdu_start);
  assign stall     = D_stall_data | mdu_term;
  assign pc_en     = ~stall;
  assign fd_wren   = ~stall;
  assign de_flush  = stall;

`ifdef MDU_STALL_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt     <= '0;
      mdu_stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (mdu_term && (mdu_stall_cnt != 32'hFFFF_FFFF))
        mdu_stall_cnt <= mdu_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
